// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, FSM state codes and
// access-length codes, plus small helpers for decoding the length field.
package mem_access_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int BYTE_W = 8;

    // FSM state encodings (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_XFER = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Raw ex_len codes; anything else is a word access
    localparam logic [2:0] LEN_CODE_B = 3'd1;
    localparam logic [2:0] LEN_CODE_H = 3'd2;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2
    } len_e;

    function automatic len_e decode_len(input logic [2:0] code);
        case (code)
            LEN_CODE_B: return LEN_B;
            LEN_CODE_H: return LEN_H;
            default:    return LEN_W;
        endcase
    endfunction

    function automatic logic [2:0] len_bytes(input len_e len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide memory bus between the MEM stage (master) and the arbiter /
// memory (slave). Read data returns one cycle after the address.
interface mem_access_if;
    import mem_access_pkg::*;

    logic              mem_req;
    logic              mem_gnt;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_wr;
    logic [BYTE_W-1:0] mem_wdata;
    logic [BYTE_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wr, mem_wdata,
        output mem_gnt, mem_rdata
    );

endinterface

// File: rtl/mem_access_load_extend.sv
// Turns the assembled little-endian load bytes into the writeback word:
// bytes and halves are zero- or sign-extended, words pass unchanged.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] raw,
    input  len_e              len,
    input  logic              sign_en,
    output logic [WORD_W-1:0] data
);

    // Select the extension that matches the access length
    always_comb begin
        // NOTE: every output gets a value before the case so no path can infer a latch.
        data = raw;
        case (len)
            LEN_B:   data = {{(WORD_W-8){sign_en & raw[7]}}, raw[7:0]};
            LEN_H:   data = {{(WORD_W-16){sign_en & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: serialises a 1/2/4-byte load or store onto the byte-wide
// memory bus, stalling the pipeline until the access completes, and
// forwards the writeback request to MEM/WB.
module mem_access
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_wb_flag,
    input  logic [REG_W-1:0]  ex_wb_rd,
    input  logic [WORD_W-1:0] ex_wb_data,
    input  logic              ex_load,
    input  logic              ex_save,
    input  logic [WORD_W-1:0] ex_mem_addr,
    input  logic [WORD_W-1:0] ex_store_data,
    input  logic [2:0]        ex_len,
    input  logic              ex_signed,
    mem_access_if.master      bus,
    output logic              stall_req,
    output logic              wb_flag,
    output logic [REG_W-1:0]  wb_rd,
    output logic [WORD_W-1:0] wb_data
);

    logic [2:0]        state;
    logic [2:0]        k;          // byte counter; reaches N in FIN
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [WORD_W-1:0] wbdata_q;
    logic [WORD_W-1:0] rdata_q;    // load bytes assembled little-endian
    logic [WORD_W-1:0] ext_data;
    len_e              len_q;
    logic              signed_q;
    logic              flag_q;
    logic              is_store_q;
    logic [REG_W-1:0]  rd_q;

    logic              mem_op;
    logic [2:0]        last_idx;
    logic [1:0]        cap_idx;
    logic              capture;

    assign mem_op   = ex_load | ex_save;
    assign last_idx = len_bytes(len_q) - 3'd1;
    // Read data lags the address by one cycle, so the byte arriving now
    // belongs to the address issued with the previous counter value.
    assign cap_idx  = 2'(k - 3'd1);
    assign capture  = !is_store_q &&
                      ((state == ST_XFER && k != 3'd0) || state == ST_FIN);

    load_extend u_load_extend (
        .raw     (rdata_q),
        .len     (len_q),
        .sign_en (signed_q),
        .data    (ext_data)
    );

    // FSM, byte counter, request latches and load-byte capture
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            k          <= 3'd0;
            addr_q     <= '0;
            store_q    <= '0;
            wbdata_q   <= '0;
            rdata_q    <= '0;
            len_q      <= LEN_B;
            signed_q   <= 1'b0;
            flag_q     <= 1'b0;
            is_store_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            if (capture) begin
                rdata_q[{cap_idx, 3'b000} +: BYTE_W] <= bus.mem_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        addr_q     <= ex_mem_addr;
                        store_q    <= ex_store_data;
                        wbdata_q   <= ex_wb_data;
                        len_q      <= decode_len(ex_len);
                        signed_q   <= ex_signed;
                        flag_q     <= ex_wb_flag;
                        rd_q       <= ex_wb_rd;
                        // A simultaneous load and save is a load
                        is_store_q <= ex_save & ~ex_load;
                        k          <= 3'd0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        k     <= 3'd0;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    k <= k + 3'd1;
                    if (k == last_idx) begin
                        // Loads need one more cycle for the last read byte
                        state <= is_store_q ? ST_DONE : ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus, stall and writeback outputs decoded from the current state
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        stall_req     = 1'b0;
        wb_flag       = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    stall_req = 1'b1;
                end else begin
                    wb_flag = ex_wb_flag;
                    wb_rd   = ex_wb_rd;
                    wb_data = ex_wb_data;
                end
            end
            ST_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
                stall_req    = 1'b1;
            end
            ST_XFER: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = addr_q + WORD_W'(k);
                bus.mem_wr    = is_store_q;
                bus.mem_wdata = store_q[{k[1:0], 3'b000} +: BYTE_W];
                stall_req     = 1'b1;
            end
            ST_FIN: begin
                stall_req = 1'b1;
            end
            ST_DONE: begin
                wb_flag = flag_q;
                wb_rd   = rd_q;
                wb_data = is_store_q ? wbdata_q : ext_data;
            end
            default: ;
        endcase
        // Pipeline-facing outputs are quiet while reset is held
        if (rst) begin
            stall_req = 1'b0;
            wb_flag   = 1'b0;
            wb_rd     = '0;
            wb_data   = '0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a byte memory with one-cycle read
// latency, an arbiter with programmable grant delay, and scoreboards of
// expected writebacks and expected bus writes.
module tb_mem_access;
    import mem_access_pkg::*;

    typedef struct packed {
        logic        flag;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wb_flag;
    logic [4:0]  ex_wb_rd;
    logic [31:0] ex_wb_data;
    logic        ex_load;
    logic        ex_save;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_len;
    logic        ex_signed;
    logic        stall_req;
    logic        wb_flag;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_if bus_if ();

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wb_flag    (ex_wb_flag),
        .ex_wb_rd      (ex_wb_rd),
        .ex_wb_data    (ex_wb_data),
        .ex_load       (ex_load),
        .ex_save       (ex_save),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .ex_len        (ex_len),
        .ex_signed     (ex_signed),
        .bus           (bus_if),
        .stall_req     (stall_req),
        .wb_flag       (wb_flag),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    // Byte memory: read data for an address appears the cycle after it
    logic [7:0] mem [256];
    always @(posedge clk) bus_if.mem_rdata <= mem[bus_if.mem_addr[7:0]];

    int          checks = 0;
    int          passed = 0;
    wb_t         exp_wb[$];
    wr_t         exp_wr[$];
    logic [31:0] addr_trace[$];
    int          last_stalls;
    wb_t         last_wb;

    // Every bus write must match the next expected store byte
    always begin
        wr_t w;
        @(negedge clk);
        #2;
        if (bus_if.mem_req === 1'b1 && bus_if.mem_wr === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL bus_write: unexpected write addr=%h data=%h",
                         bus_if.mem_addr, bus_if.mem_wdata);
            end else begin
                w = exp_wr.pop_front();
                if ({bus_if.mem_addr, bus_if.mem_wdata} !== {w.addr, w.data})
                    $display("FAIL bus_write: got %h/%h want %h/%h",
                             bus_if.mem_addr, bus_if.mem_wdata, w.addr, w.data);
                else
                    passed++;
            end
        end
    end

    task automatic clear_ex();
        ex_wb_flag    = 1'b0;
        ex_wb_rd      = '0;
        ex_wb_data    = '0;
        ex_load       = 1'b0;
        ex_save       = 1'b0;
        ex_mem_addr   = '0;
        ex_store_data = '0;
        ex_len        = '0;
        ex_signed     = 1'b0;
    endtask

    // Drive one memory op from IDLE, count stall cycles, trace bus addresses
    // and capture the writeback seen when stall drops. Ends on a negedge in IDLE.
    task automatic run_op(input logic ld, input logic sv, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [2:0] len, input logic sg,
                          input logic fl, input logic [4:0] rd, input logic [31:0] wbd,
                          input int gnt_delay);
        bit done = 0;
        addr_trace.delete();
        ex_load = ld; ex_save = sv; ex_mem_addr = addr; ex_store_data = sd;
        ex_len = len; ex_signed = sg; ex_wb_flag = fl; ex_wb_rd = rd; ex_wb_data = wbd;
        last_stalls = 0;
        last_wb     = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_if.mem_gnt = (c >= 1 + gnt_delay);
            #1;
            if (bus_if.mem_req === 1'b1) addr_trace.push_back(bus_if.mem_addr);
            if (stall_req !== 1'b1) begin
                done    = 1;
                last_wb = '{flag: wb_flag, rd: wb_rd, data: wb_data};
            end else begin
                last_stalls++;
            end
            @(negedge clk);
            if (c == 0) begin
                // Scramble ex_* so any late sampling shows up
                ex_load = 1'b0; ex_save = 1'b0; ex_mem_addr = ~addr; ex_store_data = ~sd;
                ex_len = 3'd1; ex_signed = ~sg; ex_wb_flag = ~fl; ex_wb_rd = ~rd;
                ex_wb_data = ~wbd;
            end
        end
        if (!done) last_stalls = -1;
        bus_if.mem_gnt = 1'b0;
        clear_ex();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ex();
        ex_wb_flag = 1'b1; ex_wb_rd = 5'd3; ex_wb_data = 32'h0000FFFF; ex_load = 1'b1;
        bus_if.mem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall_req, wb_flag, wb_rd, wb_data} !== 39'd0)
            $display("FAIL reset_pipe_outs: got stall=%b wb=%b/%0d/%h want all zero",
                     stall_req, wb_flag, wb_rd, wb_data);
        else passed++;
        checks++;
        if ({bus_if.mem_req, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata} !== 42'd0)
            $display("FAIL reset_bus_outs: got req=%b wr=%b addr=%h wdata=%h want all zero",
                     bus_if.mem_req, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        clear_ex();
        bus_if.mem_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        wb_t e;
        ex_wb_flag = 1'b1; ex_wb_rd = 5'd5; ex_wb_data = 32'h00001234;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd5, data: 32'h00001234});
        #1;
        e = exp_wb.pop_front();
        checks++;
        if ({wb_flag, wb_rd, wb_data} !== e || stall_req !== 1'b0 || bus_if.mem_req !== 1'b0)
            $display("FAIL passthrough_a: got %b/%0d/%h stall=%b req=%b want %b/%0d/%h stall=0 req=0",
                     wb_flag, wb_rd, wb_data, stall_req, bus_if.mem_req, e.flag, e.rd, e.data);
        else passed++;
        @(negedge clk);
        ex_wb_flag = 1'b0; ex_wb_rd = 5'd17; ex_wb_data = 32'hA5A5_0F0F;
        exp_wb.push_back('{flag: 1'b0, rd: 5'd17, data: 32'hA5A5_0F0F});
        #1;
        e = exp_wb.pop_front();
        checks++;
        if ({wb_flag, wb_rd, wb_data} !== e || stall_req !== 1'b0)
            $display("FAIL passthrough_b: got %b/%0d/%h stall=%b want %b/%0d/%h stall=0",
                     wb_flag, wb_rd, wb_data, stall_req, e.flag, e.rd, e.data);
        else passed++;
        @(negedge clk);
        clear_ex();
    endtask

    task automatic test_load_word();
        wb_t e;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h84;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd10, data: 32'h84332211});
        run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b1, 1'b1, 5'd10, 32'hDEAD_0000, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 7)
            $display("FAIL lw_stall_cycles: got %0d want 7", last_stalls);
        else passed++;
        checks++;
        if (last_wb !== e)
            $display("FAIL lw_writeback: got %b/%0d/%h want %b/%0d/%h",
                     last_wb.flag, last_wb.rd, last_wb.data, e.flag, e.rd, e.data);
        else passed++;
        checks++;
        if (addr_trace.size() != 5 || addr_trace[1] !== 32'h100 || addr_trace[4] !== 32'h103)
            $display("FAIL lw_addr_seq: got %0d bus cycles want 5 ending 0x103", addr_trace.size());
        else passed++;
    endtask

    task automatic test_load_extend();
        wb_t e;
        mem[8'h07] = 8'h80;
        mem[8'h30] = 8'h80; mem[8'h31] = 8'hFF;
        // lb signed, then lhu, lh, lbu issued back to back
        exp_wb.push_back('{flag: 1'b1, rd: 5'd1, data: 32'hFFFFFF80});
        run_op(1'b1, 1'b0, 32'h7, 32'h0, 3'd1, 1'b1, 1'b1, 5'd1, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 4 || last_wb !== e)
            $display("FAIL lb_signed: got stalls=%0d data=%h want stalls=4 data=%h",
                     last_stalls, last_wb.data, e.data);
        else passed++;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd2, data: 32'h0000FF80});
        run_op(1'b1, 1'b0, 32'h30, 32'h0, 3'd2, 1'b0, 1'b1, 5'd2, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 5 || last_wb !== e)
            $display("FAIL lhu: got stalls=%0d data=%h want stalls=5 data=%h",
                     last_stalls, last_wb.data, e.data);
        else passed++;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd3, data: 32'hFFFFFF80});
        run_op(1'b1, 1'b0, 32'h30, 32'h0, 3'd2, 1'b1, 1'b1, 5'd3, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_wb !== e)
            $display("FAIL lh_signed: got %h want %h", last_wb.data, e.data);
        else passed++;
        exp_wb.push_back('{flag: 1'b0, rd: 5'd4, data: 32'h00000080});
        run_op(1'b1, 1'b0, 32'h7, 32'h0, 3'd1, 1'b0, 1'b0, 5'd4, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_wb !== e)
            $display("FAIL lbu: got %b/%h want %b/%h", last_wb.flag, last_wb.data, e.flag, e.data);
        else passed++;
    endtask

    task automatic test_store_half();
        wb_t e;
        exp_wr.push_back('{addr: 32'h20, data: 8'hDD});
        exp_wr.push_back('{addr: 32'h21, data: 8'hCC});
        exp_wb.push_back('{flag: 1'b1, rd: 5'd12, data: 32'h5555_0000});
        run_op(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 3'd2, 1'b0, 1'b1, 5'd12, 32'h5555_0000, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 4)
            $display("FAIL sh_stall_cycles: got %0d want 4", last_stalls);
        else passed++;
        checks++;
        if (last_wb !== e)
            $display("FAIL sh_writeback: got %b/%0d/%h want %b/%0d/%h",
                     last_wb.flag, last_wb.rd, last_wb.data, e.flag, e.rd, e.data);
        else passed++;
    endtask

    task automatic test_grant_hold();
        wb_t e;
        bit  ok;
        mem[8'h60] = 8'h01; mem[8'h61] = 8'h23; mem[8'h62] = 8'h45; mem[8'h63] = 8'h67;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd20, data: 32'h67452301});
        run_op(1'b1, 1'b0, 32'h60, 32'h0, 3'd4, 1'b0, 1'b1, 5'd20, 32'h0, 3);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 10)
            $display("FAIL gnt_hold_stall: got %0d want 10", last_stalls);
        else passed++;
        ok = (addr_trace.size() == 8);
        for (int i = 0; i < 4 && ok; i++) begin
            if (addr_trace[i] !== 32'h60) ok = 0;
            if (addr_trace[4 + i] !== 32'h60 + i) ok = 0;
        end
        checks++;
        if (!ok)
            $display("FAIL gnt_hold_addr: got %0d bus cycles, want 4 held at 0x60 then 0x60..0x63",
                     addr_trace.size());
        else passed++;
        checks++;
        if (last_wb !== e)
            $display("FAIL gnt_hold_data: got %h want %h", last_wb.data, e.data);
        else passed++;
    endtask

    task automatic test_len_decode();
        wb_t e;
        // Load+save together is a load; length code 0 is a word access
        mem[8'h50] = 8'h01; mem[8'h51] = 8'h02; mem[8'h52] = 8'h03; mem[8'h53] = 8'hF4;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd7, data: 32'hF4030201});
        run_op(1'b1, 1'b1, 32'h50, 32'hDEADBEEF, 3'd0, 1'b1, 1'b1, 5'd7, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 7 || last_wb !== e)
            $display("FAIL len0_load_save: got stalls=%0d data=%h want stalls=7 data=%h",
                     last_stalls, last_wb.data, e.data);
        else passed++;
    endtask

    task automatic test_addr_wrap();
        wb_t e;
        mem[8'hFF] = 8'hA1; mem[8'h00] = 8'hB2; mem[8'h01] = 8'hC3; mem[8'h02] = 8'hD4;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd9, data: 32'hD4C3B2A1});
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 3'd4, 1'b0, 1'b1, 5'd9, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (addr_trace.size() != 5 || addr_trace[4] !== 32'h00000002)
            $display("FAIL addr_wrap: got %0d bus cycles last=%h want 5 last=00000002",
                     addr_trace.size(), addr_trace.size() > 0 ? addr_trace[addr_trace.size()-1] : 32'hx);
        else passed++;
        checks++;
        if (last_wb !== e)
            $display("FAIL addr_wrap_data: got %h want %h", last_wb.data, e.data);
        else passed++;
    endtask

    task automatic test_reset_abort();
        wb_t e;
        mem[8'h40] = 8'h99;
        ex_load = 1'b1; ex_mem_addr = 32'h40; ex_len = 3'd4; ex_wb_flag = 1'b1; ex_wb_rd = 5'd8;
        bus_if.mem_gnt = 1'b1;
        @(negedge clk);             // REQ
        clear_ex();
        repeat (2) @(negedge clk);  // XFER k=1
        #1;
        checks++;
        if (bus_if.mem_addr !== 32'h41 || stall_req !== 1'b1)
            $display("FAIL abort_setup: got addr=%h stall=%b want 00000041 stall=1",
                     bus_if.mem_addr, stall_req);
        else passed++;
        rst = 1'b1;
        ex_wb_flag = 1'b1; ex_wb_data = 32'h1111;
        #1;
        checks++;
        if ({stall_req, wb_flag, wb_data} !== 34'd0)
            $display("FAIL abort_during_rst: got stall=%b flag=%b data=%h want zeros",
                     stall_req, wb_flag, wb_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        bus_if.mem_gnt = 1'b0;
        clear_ex();
        #1;
        checks++;
        if (bus_if.mem_req !== 1'b0 || stall_req !== 1'b0 || bus_if.mem_addr !== 32'h0)
            $display("FAIL abort_idle: got req=%b stall=%b addr=%h want 0/0/0",
                     bus_if.mem_req, stall_req, bus_if.mem_addr);
        else passed++;
        ex_wb_flag = 1'b1; ex_wb_rd = 5'd9; ex_wb_data = 32'h0000CAFE;
        exp_wb.push_back('{flag: 1'b1, rd: 5'd9, data: 32'h0000CAFE});
        #1;
        e = exp_wb.pop_front();
        checks++;
        if ({wb_flag, wb_rd, wb_data} !== e || stall_req !== 1'b0)
            $display("FAIL abort_passthrough: got %b/%0d/%h stall=%b want %b/%0d/%h stall=0",
                     wb_flag, wb_rd, wb_data, stall_req, e.flag, e.rd, e.data);
        else passed++;
        @(negedge clk);
        clear_ex();
        exp_wb.push_back('{flag: 1'b1, rd: 5'd6, data: 32'hFFFFFF80});
        run_op(1'b1, 1'b0, 32'h7, 32'h0, 3'd1, 1'b1, 1'b1, 5'd6, 32'h0, 0);
        e = exp_wb.pop_front();
        checks++;
        if (last_stalls !== 4 || last_wb !== e)
            $display("FAIL abort_recover: got stalls=%0d data=%h want stalls=4 data=%h",
                     last_stalls, last_wb.data, e.data);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus_if.mem_gnt = 1'b0;
        clear_ex();
        test_reset();
        test_passthrough();
        test_load_word();
        test_load_extend();
        test_store_half();
        test_grant_hold();
        test_len_decode();
        test_addr_wrap();
        test_reset_abort();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_wr.size() != 0)
            $display("FAIL store_writes_seen: got %0d pending want 0", exp_wr.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 ex_wb_flag, ex_wb_rd[4:0], ex_wb_data[31:0]  in  register-writeback request from the EX/MEM pipeline register.
REQ-004 ex_load, ex_save  in  1 each  memory-op request; both high at once SHALL be treated as load.
REQ-005 ex_mem_addr[31:0], ex_store_data[31:0]  in  byte address and store data.
REQ-006 ex_len[2:0], ex_signed  in  access bytes (1, 2 or 4) and load sign-extend enable.
REQ-007 mem_req  out  1  bus request to the arbiter; mem_gnt  in  1  grant.
REQ-008 mem_addr[31:0], mem_wr  out  byte address and write strobe; mem_wdata[7:0]  out; mem_rdata[7:0]  in.
REQ-009 stall_req  out  1  freeze request to the stall bus.
REQ-010 wb_flag, wb_rd[4:0], wb_data[31:0]  out  writeback request to the MEM/WB register.

Function
REQ-011 States SHALL be IDLE, REQ, XFER, FIN and DONE.
REQ-012 IDLE with no load/save: wb_* SHALL equal ex_wb_* combinationally; stall_req=0; mem_req=0.
REQ-013 IDLE with load or save: latch addr, data, len, signed, rd and flag; stall_req=1; wb_flag=0; next state REQ.
REQ-014 REQ: mem_req=1, stall_req=1; mem_gnt=1 -> XFER with byte counter k=0; otherwise remain in REQ.
REQ-015 XFER: mem_req=1, mem_addr=addr+k, mem_wr=save, mem_wdata=store_data byte k (little-endian); k increments each cycle.
REQ-016 Load read latency is one cycle: byte k SHALL be captured from mem_rdata at the end of the cycle after its address is issued.
REQ-017 After issuing byte N-1, a load SHALL go to FIN to capture the last byte; a store SHALL go directly to DONE.
REQ-018 stall_req SHALL stay 1 in IDLE-accept, REQ, XFER and FIN.
REQ-019 DONE: stall_req=0, mem_req=0; wb_flag=latched flag, wb_rd=latched rd for one cycle; next state IDLE.
REQ-020 Load wb_data SHALL be the assembled bytes: zero-extended if signed=0, sign-extended from bit 7 or 15 if signed=1; a 4-byte load SHALL pass bits through unchanged.
REQ-021 Store wb_data SHALL equal the latched ex_wb_data.
REQ-022 ex_len values other than 1 or 2 SHALL be treated as 4.
REQ-023 Byte address SHALL wrap modulo 2^32; no alignment check.
REQ-024 mem_gnt SHALL be sampled only in REQ; the arbiter holds grant while mem_req=1.
REQ-025 ex_* inputs SHALL be ignored in every state other than IDLE.
REQ-026 Latency with grant ready: N-byte load stalls N+3 cycles; N-byte store stalls N+2 cycles.

Reset
REQ-027 rst SHALL force IDLE, k=0, all latches=0, mem_req=mem_wr=0, mem_addr=mem_wdata=0; this SHALL take effect on the next edge and abort any access in progress.
REQ-028 During rst, stall_req, wb_flag, wb_rd and wb_data SHALL be 0.

Structure
REQ-029 State encodings, the 32/5/8-bit width macros and the length codes SHALL live in the shared defines file.
REQ-030 Load byte assembly and extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-031 lw 0x100, gnt high, memory bytes 0x11,0x22,0x33,0x84 -> stall_req high 7 cycles; DONE wb_data=0x84332211, wb_flag=1.
REQ-032 lb signed at 0x7 with byte 0x80 -> wb_data=0xFFFFFF80; lhu with bytes 0x80,0xFF -> wb_data=0x0000FF80.
REQ-033 sh 0x20, data 0xAABBCCDD -> two write cycles: 0x20/0xDD then 0x21/0xCC; stall_req high 4 cycles; wb_flag=ex_wb_flag in DONE.
REQ-034 Load with gnt withheld 3 cycles -> stall_req held and mem_addr not advanced during the hold; result correct after grant.
REQ-035 rst pulsed at XFER k=1 -> next cycle IDLE, mem_req=0, stall_req=0; the next instruction is a normal pass-through.
REQ-036 Non-memory op, flag=1, rd=5, data=0x1234 -> same-cycle wb_* pass-through with stall_req=0; addr 0xFFFFFFFF word access wraps to 0x00000002.
